// File: rtl/fb_write_sched.sv
// Frame-buffer write scheduler: arbitrates two pixel writers onto the matrix write port
// and sequences the double-buffer swap. Define FB_SCHED_CLEAR_EN to clear the new back buffer on swap.
module fb_write_sched #(
  parameter int          FIXED_PRIO  = 0,
  parameter logic [11:0] CLEAR_VALUE = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [12:0] p0_addr,
  input  logic [11:0] p0_data,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [12:0] p1_addr,
  input  logic [11:0] p1_data,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        busy,
  output logic        wr,
  output logic [13:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        buffer_select,
  input  logic        buffer_current
);

  localparam logic [2:0] S_ARB   = 3'd0;
  localparam logic [2:0] S_SWAP  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd4;
`ifdef FB_SCHED_CLEAR_EN
  localparam logic [2:0] S_CLEAR = 3'd3;
  logic [12:0] r_clr_cnt;
`endif

  logic [2:0] r_state;
  logic       r_prio1;   // p1 wins a tie next (p0 was served last)
  logic       w_arb;
  logic       w_g1;

  // A pending swap blocks all grants so the buffer bit cannot change under a write.
  assign w_arb = (r_state == S_ARB) && !swap_req;

  always_comb begin
    w_g1 = !p0_valid;
    if (FIXED_PRIO == 0) w_g1 = r_prio1 || !p0_valid;
  end

  assign p1_ready = w_arb && p1_valid && w_g1;
  assign p0_ready = w_arb && p0_valid && !p1_ready;
  assign busy     = (r_state != S_ARB);
  assign swap_ack = (r_state == S_ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_ARB;
      r_prio1       <= 1'b0;
      wr            <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      buffer_select <= 1'b0;
`ifdef FB_SCHED_CLEAR_EN
      r_clr_cnt     <= '0;
`endif
    end else begin
      wr <= 1'b0;
      if (p0_ready) begin
        wr      <= 1'b1;
        wr_addr <= {~buffer_select, p0_addr};
        wr_data <= p0_data;
        r_prio1 <= 1'b1;
      end else if (p1_ready) begin
        wr      <= 1'b1;
        wr_addr <= {~buffer_select, p1_addr};
        wr_data <= p1_data;
        r_prio1 <= 1'b0;
      end

      case (r_state)
        S_ARB:  if (swap_req) r_state <= S_SWAP;
        S_SWAP: begin
          buffer_select <= ~buffer_select;
          r_state       <= S_WAIT;
        end
        // Old front buffer is only safe once the driver has adopted the new one.
        S_WAIT: if (buffer_current == buffer_select) begin
`ifdef FB_SCHED_CLEAR_EN
          r_clr_cnt <= '0;
          r_state   <= S_CLEAR;
`else
          r_state   <= S_ACK;
`endif
        end
`ifdef FB_SCHED_CLEAR_EN
        S_CLEAR: begin
          wr        <= 1'b1;
          wr_addr   <= {~buffer_select, r_clr_cnt};
          wr_data   <= CLEAR_VALUE;
          r_clr_cnt <= r_clr_cnt + 13'd1;
          if (r_clr_cnt == 13'h1FFF) r_state <= S_ACK;
        end
`endif
        S_ACK:   r_state <= S_ARB;
        default: r_state <= S_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched: round-robin and fixed-priority instances share stimulus.
module tb_fb_write_sched;

  localparam logic [11:0] CLR = 12'h5A5;

  logic        clk, rst;
  logic        p0_valid, p1_valid, swap_req, buffer_current;
  logic [12:0] p0_addr, p1_addr;
  logic [11:0] p0_data, p1_data;

  logic        p0_ready, p1_ready, swap_ack, busy, wr, buffer_select;
  logic [13:0] wr_addr;
  logic [11:0] wr_data;
  logic        f_p0_ready, f_p1_ready, f_swap_ack, f_busy, f_wr, f_buffer_select;
  logic [13:0] f_wr_addr;
  logic [11:0] f_wr_data;

  fb_write_sched #(.FIXED_PRIO(0), .CLEAR_VALUE(CLR)) u_rr (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .busy(busy),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .buffer_select(buffer_select), .buffer_current(buffer_current));

  fb_write_sched #(.FIXED_PRIO(1), .CLEAR_VALUE(CLR)) u_fp (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(f_p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(f_p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
    .swap_req(swap_req), .swap_ack(f_swap_ack), .busy(f_busy),
    .wr(f_wr), .wr_addr(f_wr_addr), .wr_data(f_wr_data),
    .buffer_select(f_buffer_select), .buffer_current(buffer_current));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        p0v, p1v;
    logic [12:0] a0;
    logic [11:0] d0;
    logic [12:0] a1;
    logic [11:0] d1;
    logic        r0, r1, wr;
    logic [13:0] addr;
    logic [11:0] data;
    logic        fr0, fr1;
    logic [13:0] faddr;
    logic [11:0] fdata;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic ok;
    vt[0] = '{1'b1, 1'b0, 13'h0805, 12'hF0A, 13'h0000, 12'h000, 1'b1, 1'b0, 1'b1, 14'h2805, 12'hF0A, 1'b1, 1'b0, 14'h2805, 12'hF0A};
    vt[1] = '{1'b0, 1'b0, 13'h0000, 12'h000, 13'h0000, 12'h000, 1'b0, 1'b0, 1'b0, 14'h2805, 12'hF0A, 1'b0, 1'b0, 14'h2805, 12'hF0A};
    vt[2] = '{1'b0, 1'b1, 13'h0000, 12'h000, 13'h0100, 12'hABC, 1'b0, 1'b1, 1'b1, 14'h2100, 12'hABC, 1'b0, 1'b1, 14'h2100, 12'hABC};
    vt[3] = '{1'b1, 1'b1, 13'h0001, 12'h111, 13'h1FFF, 12'h222, 1'b1, 1'b0, 1'b1, 14'h2001, 12'h111, 1'b1, 1'b0, 14'h2001, 12'h111};
    vt[4] = '{1'b1, 1'b1, 13'h0002, 12'h333, 13'h0003, 12'h444, 1'b0, 1'b1, 1'b1, 14'h2003, 12'h444, 1'b1, 1'b0, 14'h2002, 12'h333};
    vt[5] = '{1'b1, 1'b1, 13'h0004, 12'h555, 13'h1005, 12'h666, 1'b1, 1'b0, 1'b1, 14'h2004, 12'h555, 1'b1, 1'b0, 14'h2004, 12'h555};
    vt[6] = '{1'b1, 1'b1, 13'h0806, 12'h777, 13'h0007, 12'h888, 1'b0, 1'b1, 1'b1, 14'h2007, 12'h888, 1'b1, 1'b0, 14'h2806, 12'h777};
    vt[7] = '{1'b0, 1'b0, 13'h0000, 12'h000, 13'h0000, 12'h000, 1'b0, 1'b0, 1'b0, 14'h2007, 12'h888, 1'b0, 1'b0, 14'h2806, 12'h777};

    rst = 1'b1; p0_valid = 0; p1_valid = 0; swap_req = 0; buffer_current = 0;
    p0_addr = '0; p1_addr = '0; p0_data = '0; p1_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wr", wr, 0);          chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);   chk("rst_bsel", buffer_select, 0);
    chk("rst_ack", swap_ack, 0);   chk("rst_busy", busy, 0);
    chk("rst_r0", p0_ready, 0);    chk("rst_r1", p1_ready, 0);

    // Arbitration table: inputs set at negedge, readys checked before the edge, writes after.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      p0_valid = vt[i].p0v; p1_valid = vt[i].p1v;
      p0_addr = vt[i].a0; p0_data = vt[i].d0; p1_addr = vt[i].a1; p1_data = vt[i].d1;
      #1;
      chk($sformatf("v%0d_r0", i), p0_ready, vt[i].r0);
      chk($sformatf("v%0d_r1", i), p1_ready, vt[i].r1);
      chk($sformatf("v%0d_fr0", i), f_p0_ready, vt[i].fr0);
      chk($sformatf("v%0d_fr1", i), f_p1_ready, vt[i].fr1);
      @(negedge clk);
      chk($sformatf("v%0d_wr", i), wr, vt[i].wr);
      chk($sformatf("v%0d_addr", i), wr_addr, vt[i].addr);
      chk($sformatf("v%0d_data", i), wr_data, vt[i].data);
      chk($sformatf("v%0d_fwr", i), f_wr, vt[i].wr);
      chk($sformatf("v%0d_faddr", i), f_wr_addr, vt[i].faddr);
      chk($sformatf("v%0d_fdata", i), f_wr_data, vt[i].fdata);
    end

    // Reset while waiting for the display to adopt the new buffer.
    swap_req = 1'b1;
    @(negedge clk);
    chk("rw_busy_swap", busy, 1);
    @(negedge clk);
    chk("rw_bsel_toggled", buffer_select, 1);
    repeat (3) @(negedge clk);
    chk("rw_still_wait", busy, 1);
    rst = 1'b1; swap_req = 1'b0;
    @(negedge clk);
    chk("rw_bsel", buffer_select, 0); chk("rw_busy", busy, 0);
    chk("rw_wr", wr, 0);              chk("rw_ack", swap_ack, 0);
    rst = 1'b0;
    p0_valid = 1'b1; p0_addr = 13'h0123; p0_data = 12'h456;
    #1;
    chk("rw_r0_after", p0_ready, 1);
    @(negedge clk);
    chk("rw_wr_after", wr, 1); chk("rw_addr_after", wr_addr, 14'h2123);
    chk("rw_data_after", wr_data, 12'h456);

    // Full swap with p0 held valid; display lags 100 cycles.
    p0_addr = 13'h0010; p0_data = 12'h0AA; swap_req = 1'b1;
    #1;
    chk("sw_r0_blocked", p0_ready, 0);
    @(negedge clk);
    chk("sw_bsel_pre", buffer_select, 0); chk("sw_busy", busy, 1);
    chk("sw_r0_swap", p0_ready, 0);
    @(negedge clk);
    chk("sw_bsel_post", buffer_select, 1);
    ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (p0_ready || p1_ready || f_p0_ready || !busy || swap_ack || wr || buffer_select !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    chk("sw_wait_stall", ok, 1);
    buffer_current = 1'b1;
    @(negedge clk);
`ifdef FB_SCHED_CLEAR_EN
    ok = 1'b1;
    for (int k = 0; k < 8192; k++) begin
      @(negedge clk);
      if (!wr || wr_addr !== 14'(k) || wr_data !== CLR || p0_ready) ok = 1'b0;
    end
    chk("clr_seq", ok, 1);
`endif
    chk("sw_ack", swap_ack, 1); chk("sw_ack_busy", busy, 1);
    chk("sw_ack_r0", p0_ready, 0);
    swap_req = 1'b0;
    @(negedge clk);
    chk("sw_ack_pulse", swap_ack, 0); chk("sw_idle", busy, 0);
    chk("sw_r0_resume", p0_ready, 1);
    @(negedge clk);
    chk("sw_wr_post", wr, 1); chk("sw_addr_post", wr_addr, 14'h0010);
    chk("sw_fbsel", f_buffer_select, 1);
    p0_valid = 1'b0;
    @(negedge clk);
    chk("sw_wr_end", wr, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
